// File: rtl/sd_tx_fill_pkg.sv
// Shared types and helpers for the SD TX FIFO fill sequencer.
package sd_tx_fill_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SPACE,
    FETCH,
    DONE,
    ERR
  } fill_state_e;

  localparam int unsigned WORD_BYTES = 4;

  // Length of the next burst: whatever is left of the block, capped at burst.
  function automatic int unsigned min_burst(input int unsigned wrem, input int unsigned burst);
    return (wrem < burst) ? wrem : burst;
  endfunction

endpackage

// File: rtl/sd_tx_fill_cnt.sv
// Address / words-remaining / blocks-remaining counter bank for the fill sequencer.
module sd_tx_fill_cnt
  import sd_tx_fill_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned BLKW_W = 10,
  parameter int unsigned BLKC_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [BLKW_W-1:0] load_words,
  input  logic [BLKC_W-1:0] load_blocks,
  input  logic              step,
  input  logic              next_blk,
  output logic [ADDR_W-1:0] addr,
  output logic [BLKW_W-1:0] wrem,
  output logic              wrem_last,
  output logic              brem_last
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BLKW_W-1:0] wrem_q, wrem_d;
  logic [BLKW_W-1:0] wload_q, wload_d;
  logic [BLKC_W-1:0] brem_q, brem_d;

  // Next-count logic: load on start, advance one word per accepted ack.
  always_comb begin
    addr_d  = addr_q;
    wrem_d  = wrem_q;
    wload_d = wload_q;
    brem_d  = brem_q;
    if (load) begin
      addr_d  = load_addr;
      wrem_d  = load_words;
      wload_d = load_words;
      brem_d  = load_blocks;
    end else if (step) begin
      addr_d = addr_q + ADDR_W'(WORD_BYTES);
      if (next_blk) begin
        // Last word of a non-final block: start the next block in the same edge.
        wrem_d = wload_q;
        brem_d = brem_q - BLKC_W'(1);
      end else begin
        wrem_d = wrem_q - BLKW_W'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wrem_q  <= '0;
      wload_q <= '0;
      brem_q  <= '0;
    end else begin
      addr_q  <= addr_d;
      wrem_q  <= wrem_d;
      wload_q <= wload_d;
      brem_q  <= brem_d;
    end
  end

  assign addr      = addr_q;
  assign wrem      = wrem_q;
  assign wrem_last = (wrem_q == BLKW_W'(1));
  assign brem_last = (brem_q == BLKC_W'(1));

endmodule

// File: rtl/sd_tx_fill_ctrl.sv
// SD TX FIFO write-side fill sequencer: fetches block data over a read-master
// handshake and writes it into the FIFO in space-guaranteed bursts.
// Optional byte swap of each word is enabled by defining SD_TX_FILL_BSWAP_EN.
module sd_tx_fill_ctrl
  import sd_tx_fill_pkg::*;
#(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned BURST  = 8,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned BLKW_W = 10,
  parameter int unsigned BLKC_W = 16
) (
  input  logic              wclk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [BLKW_W-1:0] blk_words,
  input  logic [BLKC_W-1:0] blk_count,
`ifdef SD_TX_FILL_BSWAP_EN
  input  logic              bswap,
`endif
  output logic              m_req,
  output logic [ADDR_W-1:0] m_addr,
  input  logic              m_ack,
  input  logic [31:0]       m_dat,
  input  logic              m_err,
  output logic [31:0]       fifo_d,
  output logic              fifo_wr,
  input  logic              fifo_full,
  input  logic [5:0]        fifo_level,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned BLEN_W = $clog2(BURST + 1);

  fill_state_e       state_q, state_d;
  logic [BLEN_W-1:0] bcnt_q, bcnt_d;
  logic [BLEN_W-1:0] blen_q, blen_d;
  logic [31:0]       fifo_d_q, fifo_d_d;
  logic              fifo_wr_q, fifo_wr_d;
  logic              m_req_q, m_req_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              cnt_load, cnt_step, cnt_next_blk;
  logic [ADDR_W-1:0] cnt_addr;
  logic [BLKW_W-1:0] cnt_wrem;
  logic              cnt_wrem_last, cnt_brem_last;
  logic [31:0]       wdata;
  int unsigned       blen_now;
  logic              space_ok;
  logic              ovf;

  sd_tx_fill_cnt #(
    .ADDR_W (ADDR_W),
    .BLKW_W (BLKW_W),
    .BLKC_W (BLKC_W)
  ) u_cnt (
    .clk         (wclk),
    .rst         (rst),
    .load        (cnt_load),
    .load_addr   ({base_addr[ADDR_W-1:2], 2'b00}),
    .load_words  (blk_words),
    .load_blocks (blk_count),
    .step        (cnt_step),
    .next_blk    (cnt_next_blk),
    .addr        (cnt_addr),
    .wrem        (cnt_wrem),
    .wrem_last   (cnt_wrem_last),
    .brem_last   (cnt_brem_last)
  );

`ifdef SD_TX_FILL_BSWAP_EN
  logic bswap_q, bswap_d;

  // Byte-swap mode is captured with the transfer parameters at start.
  always_comb begin
    bswap_d = cnt_load ? bswap : bswap_q;
  end

  // Byte-swap mode register.
  always_ff @(posedge wclk) begin
    if (rst) bswap_q <= 1'b0;
    else     bswap_q <= bswap_d;
  end

  assign wdata = bswap_q ? {m_dat[7:0], m_dat[15:8], m_dat[23:16], m_dat[31:24]} : m_dat;
`else
  assign wdata = m_dat;
`endif

  // Comparing level + burst against depth avoids underflow if level ever exceeds depth.
  assign blen_now = min_burst(32'(cnt_wrem), BURST);
  assign space_ok = (32'(fifo_level) + blen_now) <= 32'(DEPTH);
  assign ovf      = fifo_wr_q && fifo_full &&
                    (state_q inside {WAIT_SPACE, FETCH, DONE});

  // Next-state and registered-output decode; error then abort override the normal flow.
  always_comb begin
    state_d      = state_q;
    bcnt_d       = bcnt_q;
    blen_d       = blen_q;
    fifo_d_d     = fifo_d_q;
    fifo_wr_d    = 1'b0;
    cnt_load     = 1'b0;
    cnt_step     = 1'b0;
    cnt_next_blk = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (blk_words == '0 || blk_count == '0) begin
            state_d = ERR;
          end else begin
            state_d  = WAIT_SPACE;
            cnt_load = 1'b1;
          end
        end
      end
      WAIT_SPACE: begin
        if (space_ok) begin
          state_d = FETCH;
          bcnt_d  = '0;
          blen_d  = BLEN_W'(blen_now);
        end
      end
      FETCH: begin
        if (m_err) begin
          state_d = ERR;
        end else if (m_ack) begin
          fifo_wr_d = 1'b1;
          fifo_d_d  = wdata;
          bcnt_d    = bcnt_q + BLEN_W'(1);
          cnt_step  = 1'b1;
          if ((bcnt_q + BLEN_W'(1)) == blen_q) begin
            if (!cnt_wrem_last) begin
              state_d = WAIT_SPACE;
            end else if (!cnt_brem_last) begin
              cnt_next_blk = 1'b1;
              state_d      = WAIT_SPACE;
            end else begin
              state_d = DONE;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (ovf) begin
      state_d      = ERR;
      fifo_wr_d    = 1'b0;
      cnt_step     = 1'b0;
      cnt_next_blk = 1'b0;
    end

    if (abort) begin
      state_d      = IDLE;
      fifo_wr_d    = 1'b0;
      cnt_load     = 1'b0;
      cnt_step     = 1'b0;
      cnt_next_blk = 1'b0;
    end

    // Outputs are decoded from the next state so they line up with it after the edge.
    m_req_d = (state_d == FETCH);
    busy_d  = (state_d == WAIT_SPACE) || (state_d == FETCH);
    done_d  = (state_d == DONE);
    err_d   = (state_d == ERR);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge wclk) begin
    if (rst) begin
      state_q   <= IDLE;
      bcnt_q    <= '0;
      blen_q    <= '0;
      fifo_d_q  <= '0;
      fifo_wr_q <= 1'b0;
      m_req_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      blen_q    <= blen_d;
      fifo_d_q  <= fifo_d_d;
      fifo_wr_q <= fifo_wr_d;
      m_req_q   <= m_req_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign m_req   = m_req_q;
  assign m_addr  = cnt_addr;
  assign fifo_d  = fifo_d_q;
  assign fifo_wr = fifo_wr_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: doc/sd_tx_fill_ctrl.md
Name: sd_tx_fill_ctrl

Overview:
Write-side sequencer for the SD TX FIFO. It fetches block data from system memory through a simple read-master handshake and pushes it into the FIFO write port in bursts. A burst starts only when the FIFO has guaranteed free space. It counts words per block and blocks per transfer, and signals completion, abort and error to the SD data controller.

Parameters:
DEPTH, 32, FIFO depth in 32-bit words; the FIFO level input is 6 bits wide.
BURST, 8, maximum words per read burst; must be 1..DEPTH.
ADDR_W, 32, memory address width.
BLKW_W, 10, width of the words-per-block field.
BLKC_W, 16, width of the block-count field.

Ports:
wclk  in  1  FIFO write-side clock; the only clock of this block.
rst  in  1  reset, synchronous, active-high.
start  in  1  one-cycle pulse that starts a transfer; ignored while busy.
abort  in  1  synchronous abort of the transfer.
base_addr  in  ADDR_W  byte address of the first word; bits[1:0] ignored.
blk_words  in  BLKW_W  words per block.
blk_count  in  BLKC_W  number of blocks.
m_req  out  1  read request; held high for the whole burst.
m_addr  out  ADDR_W  word-aligned read address.
m_ack  in  1  read data valid and accepted, one word per cycle.
m_dat  in  32  read data.
m_err  in  1  bus error; sampled only while m_req is high.
fifo_d  out  32  FIFO write data.
fifo_wr  out  1  FIFO write strobe.
fifo_full  in  1  FIFO full flag.
fifo_level  in  6  FIFO occupancy in words, write-clock domain.
busy  out  1  high from the cycle after an accepted start until DONE, IDLE or ERR.
done  out  1  one-cycle pulse when the last word of the last block has been written.
err  out  1  one-cycle pulse on a bus error, a FIFO overflow or a zero-length request.

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0.
- Counters:
  - addr: ADDR_W bits; increments by 4 and wraps modulo 2^ADDR_W.
  - wrem: words remaining in the current block.
  - brem: blocks remaining.
  - bcnt: acknowledgements counted in the current burst.
- State IDLE:
  - On start: latch base_addr, load wrem = blk_words and brem = blk_count, go to WAIT_SPACE.
  - If blk_words == 0 or blk_count == 0: go to ERR instead.
- State WAIT_SPACE:
  - Compute blen = min(BURST, wrem) and free = DEPTH - fifo_level.
  - When free >= blen: go to FETCH with bcnt = 0.
  - While free < blen: stay, with m_req low.
- State FETCH:
  - m_req is high and m_addr = addr.
  - On each m_ack: register m_dat into fifo_d and assert fifo_wr on the next cycle (1-cycle latency). Then addr += 4, wrem -= 1, bcnt += 1.
  - m_req falls on the same edge that captures the ack that makes bcnt == blen. No extra request cycle.
  - After the burst:
    - If wrem > 0: go to WAIT_SPACE.
    - If wrem == 0 and brem > 1: decrement brem, reload wrem = blk_words, go to WAIT_SPACE.
    - If wrem == 0 and brem == 1: go to DONE.
  - m_err high with m_req high: go to ERR. Any ack in that same cycle is discarded.
- State DONE:
  - Lasts one cycle; the final fifo_wr is issued in this cycle.
  - done = 1, busy falls, then IDLE.
- State ERR:
  - Lasts one cycle: err = 1, m_req = 0, then IDLE.
  - Writes already registered still complete.
- FIFO overflow: if fifo_full is high in a cycle where fifo_wr is high, pulse err. The write still issues, the FIFO drops it, and the FSM goes to ERR.
- Abort:
  - From any state, the next state is IDLE; m_req, busy and fifo_wr are all low on the next cycle.
  - An m_ack in the abort cycle is discarded.
  - No done pulse and no err pulse.
- Priority: rst > abort > m_err > start.
- start while busy is ignored and has no side effects.

Optional Feature:
- Macro: SD_TX_FILL_BSWAP_EN.
- Defined: adds input bswap (1 bit, sampled at start). When bswap was set, fifo_d = {m_dat[7:0], m_dat[15:8], m_dat[23:16], m_dat[31:24]}.
- Undefined: the port is absent and fifo_d = m_dat unchanged.

Decomposition:
- Package sd_tx_fill_pkg:
  - fill_state_e enum: IDLE, WAIT_SPACE, FETCH, DONE, ERR.
  - WORD_BYTES = 4.
  - Helper function min_burst(wrem, BURST).
- One sub-module, sd_tx_fill_cnt: the addr/wrem/brem counter bank with load, decrement and terminal flags. The FSM stays in the top.

Test Plan:
- Single block: base_addr = 0x1000, blk_words = 16, blk_count = 1, m_ack every cycle, fifo_level = 0.
  - Expect two bursts of 8 with m_addr 0x1000..0x103C.
  - Expect 16 fifo_wr and exactly one done pulse; busy low afterwards.
- Space throttle: fifo_level held at 28, DEPTH = 32, blk_words = 8.
  - Expect m_req to stay low.
  - After fifo_level drops to 24, expect m_req high within 1 cycle.
- Multi-block with short tail: blk_words = 10, blk_count = 3.
  - Expect a burst pattern of 8,2 repeated 3 times, 30 writes and a final m_addr of 0x1074.
- Abort mid-burst after the 5th ack: expect IDLE next cycle, no done, no err, exactly 5 fifo_wr.
  - A new start then restarts cleanly from the new base_addr.
- Errors:
  - m_err on the 3rd cycle of a burst: one err pulse, 2 writes, the ack in the error cycle discarded.
  - start with blk_words = 0: err pulse and no m_req.
- Address wrap and ignored start: base_addr = 0xFFFFFFF8, blk_words = 4.
  - Expect m_addr sequence FFFFFFF8, FFFFFFFC, 00000000, 00000004.
  - A start pulse issued mid-transfer is ignored.
